im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader.sv | 139 +++++++++++++
 tb/tb_im_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// im_loader: UART frame loader that streams a length-prefixed byte image into instruction memory
// Frame: 0xA5, LEN_HI, LEN_LO, N data bytes, then an XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module im_loader #(
  parameter int unsigned MEM_SIZE       = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] pc,
  output logic        prog_mode,
  output logic        wr_en,
  output logic [7:0]  data_out,
  output logic [31:0] addr_out,
  output logic        load_done,
  output logic        load_err,
  output logic        ack_valid,
  output logic [7:0]  ack_data
);
  localparam int unsigned CAP = MEM_SIZE * 1024;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHECK;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  state_t        r_state, w_next;
  logic [15:0]   r_len, r_rcv;
  logic [31:0]   r_addr;
  logic [TW-1:0] r_to;
  logic          r_prog, r_wr_en, r_done, r_err, r_ack_v;
  logic [7:0]    r_data, r_ack_d;
  logic [15:0]   w_len;
  logic          w_sync, w_busy, w_timeout;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif
  assign w_len     = {r_len[7:0], rx_data};
  assign w_sync    = r_state == S_IDLE && rx_valid && rx_data == SYNC;
  assign w_busy    = r_state == S_LEN_HI || r_state == S_LEN_LO || r_state == S_DATA
`ifdef LOADER_CHECKSUM_EN
                     || r_state == S_CHECK
`endif
                     ;
  assign w_timeout = !rx_valid && r_to == TO_MAX;
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // Next-state logic; bytes arriving in DONE/ERROR are dropped
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = w_sync ? S_LEN_HI : S_IDLE;
      S_LEN_HI: w_next = rx_valid ? S_LEN_LO : w_timeout ? S_ERROR : S_LEN_HI;
      S_LEN_LO: w_next = rx_valid ? ((32'(w_len) > CAP) ? S_ERROR : (w_len == 16'd0) ? S_FIN : S_DATA)
                                  : w_timeout ? S_ERROR : S_LEN_LO;
      S_DATA:   w_next = (rx_valid && r_rcv == r_len - 16'd1) ? S_FIN : w_timeout ? S_ERROR : S_DATA;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK:  w_next = rx_valid ? ((rx_data == r_csum) ? S_DONE : S_ERROR) : w_timeout ? S_ERROR : S_CHECK;
`endif
      default:  w_next = S_IDLE;
    endcase
  end
  // Inter-byte idle counter, saturating at the timeout limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_to <= '0;
    else if (rx_valid || !w_busy) r_to <= '0;
    else if (r_to != TO_MAX)     r_to <= r_to + TW'(1);
  end
  // Datapath: length capture, byte writes, address advance, status and ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prog  <= 1'b0;
      r_wr_en <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_rcv   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ack_v <= 1'b0;
      r_ack_d <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_wr_en <= r_state == S_DATA && rx_valid;
      if (r_state == S_DATA && rx_valid) begin
        r_data <= rx_data;
        r_rcv  <= r_rcv + 16'd1;
`ifdef LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ rx_data;
`endif
      end
      if (r_wr_en) r_addr <= r_addr + 32'd1;
      if ((r_state == S_LEN_HI || r_state == S_LEN_LO) && rx_valid) r_len <= w_len;
      if (w_sync) begin
        r_prog <= 1'b1;
        r_addr <= '0;
        r_rcv  <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_csum <= '0;
`endif
      end
      if (r_state == S_DONE || r_state == S_ERROR) r_prog <= 1'b0;
      r_done  <= w_next == S_DONE;
      r_ack_v <= w_next == S_DONE || w_next == S_ERROR;
      if (w_next == S_DONE)  r_ack_d <= ACK;
      if (w_next == S_ERROR) r_ack_d <= NAK;
      r_err   <= (w_next == S_ERROR) ? 1'b1 : w_sync ? 1'b0 : r_err;
    end
  end
  assign prog_mode = r_prog;
  assign wr_en     = r_wr_en;
  assign data_out  = r_data;
  assign addr_out  = r_prog ? r_addr : pc;
  assign load_done = r_done;
  assign load_err  = r_err;
  assign ack_valid = r_ack_v;
  assign ack_data  = r_ack_d;
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed frames with write/ack scoreboards for im_loader
module tb_im_loader;
  localparam int TO = 40;
  logic        clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] pc = '0;
  logic        prog_mode, wr_en, load_done, load_err, ack_valid;
  logic [7:0]  data_out, ack_data;
  logic [31:0] addr_out;
  int checks = 0, fails = 0, acks_seen = 0, writes_seen = 0;
  logic [39:0] wq[$];
  logic [7:0]  aq[$];
  logic [39:0] w_exp;
  logic [7:0]  a_exp;
  logic [7:0]  cs;
  logic        exp_err;

  im_loader #(.MEM_SIZE(5), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .pc(pc),
    .prog_mode(prog_mode), .wr_en(wr_en), .data_out(data_out), .addr_out(addr_out),
    .load_done(load_done), .load_err(load_err), .ack_valid(ack_valid), .ack_data(ack_data)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: compare every write strobe and ack against queued expectations
  always @(negedge clk) begin
    if (wr_en) begin
      writes_seen++;
      checks++;
      assert (wq.size() != 0) else begin fails++; $error("FAIL wr_unexpected got addr=%h data=%h exp no write", addr_out, data_out); end
      if (wq.size() != 0) begin
        w_exp = wq.pop_front();
        checks++;
        assert ({addr_out, data_out} === w_exp) else begin fails++; $error("FAIL wr_data got addr=%h data=%h exp addr=%h data=%h", addr_out, data_out, w_exp[39:8], w_exp[7:0]); end
      end
    end
    if (ack_valid) begin
      acks_seen++;
      checks++;
      assert (aq.size() != 0) else begin fails++; $error("FAIL ack_unexpected got ack=%h exp no ack", ack_data); end
      if (aq.size() != 0) begin
        a_exp = aq.pop_front();
        checks++;
        assert (ack_data === a_exp) else begin fails++; $error("FAIL ack_data got %h exp %h", ack_data, a_exp); end
        checks++;
        assert (load_done === (a_exp == 8'h06)) else begin fails++; $error("FAIL ack_done got %b exp %b", load_done, a_exp == 8'h06); end
        checks++;
        assert (load_err === (a_exp == 8'h15)) else begin fails++; $error("FAIL ack_err got %b exp %b", load_err, a_exp == 8'h15); end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin fails++; $error("FAIL %s got %h exp %h", tag, got, exp); end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic data(input logic [31:0] a, input logic [7:0] b);
    wq.push_back({a, b});
    send(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int target);
    for (int k = 0; k < 200 && acks_seen < target; k++) @(posedge clk);
    #1;
    chk("ack_wait", acks_seen, target);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prog", prog_mode, 0);
    chk("rst_wr", wr_en, 0);
    chk("rst_data", data_out, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_ackv", ack_valid, 0);
    chk("rst_ackd", ack_data, 0);
    rst_n = 1'b1;
    idle(1);
    pc = 32'h40;
    #1 chk("idle_pc", addr_out, 32'h40);
    send(8'h00);
    send(8'hFF);
    idle(3);
    chk("stray_prog", prog_mode, 0);
    chk("stray_ack", acks_seen, 0);
    chk("stray_pc", addr_out, 32'h40);
    // Frame 1: four bytes, good checksum
    send(8'hA5);
    chk("sync_prog", prog_mode, 1);
    chk("sync_addr", addr_out, 0);
    send(8'h00);
    send(8'h04);
    data(0, 8'h11); data(1, 8'h22); data(2, 8'h33);
    aq.push_back(8'h06);
    data(3, 8'h44);
    cs = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
`ifdef LOADER_CHECKSUM_EN
    send(cs);
`endif
    wait_acks(1);
    idle(1);
    chk("f1_prog", prog_mode, 0);
    chk("f1_err", load_err, 0);
    // Frame 2: same payload, corrupted checksum when checksumming is built in
`ifdef LOADER_CHECKSUM_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(8'hA5); send(8'h00); send(8'h04);
    aq.push_back(exp_err ? 8'h15 : 8'h06);
    data(0, 8'h11); data(1, 8'h22); data(2, 8'h33); data(3, 8'h44);
`ifdef LOADER_CHECKSUM_EN
    send(cs ^ 8'h01);
`endif
    wait_acks(2);
    idle(1);
    chk("f2_err", load_err, exp_err);
    chk("f2_prog", prog_mode, 0);
    // Frame 3: length one beyond capacity
    send(8'hA5);
    chk("sync_clr_err", load_err, 0);
    send(8'h14);
    aq.push_back(8'h15);
    send(8'h01);
    wait_acks(3);
    idle(1);
    chk("f3_err", load_err, 1);
    chk("f3_prog", prog_mode, 0);
    // Frame 4: sync value inside data is plain data
    send(8'hA5); send(8'h00); send(8'h03);
    aq.push_back(8'h06);
    data(0, 8'hA5); data(1, 8'hA5); data(2, 8'hA5);
`ifdef LOADER_CHECKSUM_EN
    send(8'hA5);
`endif
    wait_acks(4);
    idle(1);
    chk("f4_err", load_err, 0);
    // Frame 5: empty payload
    send(8'hA5); send(8'h00);
    aq.push_back(8'h06);
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    wait_acks(5);
    idle(1);
    chk("f5_prog", prog_mode, 0);
    // Frame 6: stall mid-data until timeout
    send(8'hA5); send(8'h00); send(8'h02);
    data(0, 8'h01);
    idle(TO - 5);
    chk("to_early", acks_seen, 5);
    chk("to_prog", prog_mode, 1);
    aq.push_back(8'h15);
    wait_acks(6);
    idle(1);
    chk("to_err", load_err, 1);
    chk("to_prog_off", prog_mode, 0);
    // Frame 7: reset mid-frame aborts silently
    send(8'hA5); send(8'h00); send(8'h03);
    data(0, 8'h11);
    idle(1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_prog", prog_mode, 0);
    chk("mid_rst_wr", wr_en, 0);
    chk("mid_rst_err", load_err, 0);
    idle(1);
    rst_n = 1'b1;
    idle(TO + 20);
    chk("mid_rst_noack", acks_seen, 6);
    chk("mid_rst_pc", addr_out, 32'h40);
    chk("write_count", writes_seen, 13);
    chk("wq_empty", wq.size(), 0);
    chk("aq_empty", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
